// File: rtl/peak_out_pkg.sv
// Shared types and helpers for the peak stream output block (state enum,
// NO_PEAK constant, packed-pixel slicing).
package peak_out_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam int unsigned SLICE_MAX = 1024;

  // All-ones peak marker for an NP-bit bin index.
  function automatic logic [31:0] no_peak(input int unsigned np);
    return (np >= 32) ? '1 : ((32'd1 << np) - 32'd1);
  endfunction

  // Extract pixel p (NP bits at [p*np +: np]) from a zero-extended packed vector.
  function automatic logic [31:0] pixel_slice(input logic [SLICE_MAX-1:0] vec,
                                              input int unsigned p,
                                              input int unsigned np);
    logic [SLICE_MAX-1:0] sh;
    sh = vec >> (p * np);
    return sh[31:0] & no_peak(np);
  endfunction

endpackage

// File: rtl/peak_iir_cell.sv
// Per-pixel one-tap temporal IIR (rounding average with the previous frame).
// Built only when PEAK_IIR_EN is defined.
`ifdef PEAK_IIR_EN
module peak_iir_cell
  import peak_out_pkg::*;
#(
  parameter int NP = 10
) (
  input  logic          clk,
  input  logic          res,
  input  logic [NP-1:0] new_val,
  input  logic          update,
  output logic [NP-1:0] filt_val
);

  localparam logic [NP-1:0] NO_PEAK_V = NP'(no_peak(NP));

  logic [NP-1:0] hist;
  logic          hist_vld;
  logic [NP:0]   sum;

  // Sum is one bit wider so the rounded average never overflows NP bits.
  always_comb begin
    sum      = {1'b0, hist} + {1'b0, new_val} + (NP+1)'(1);
    filt_val = new_val;
    if (new_val == NO_PEAK_V) begin
      filt_val = NO_PEAK_V;
    end else if (hist_vld) begin
      filt_val = sum[NP:1];
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      hist     <= '0;
      hist_vld <= 1'b0;
    end else if (update && (new_val != NO_PEAK_V)) begin
      hist     <= filt_val;
      hist_vld <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/peak_stream_out.sv
// Captures a completed frame of per-pixel peaks and streams it one pixel per
// handshake. Optional temporal smoothing via macro PEAK_IIR_EN.
module peak_stream_out
  import peak_out_pkg::*;
#(
  parameter int NP     = 10,
  parameter int PIXELS = 3,
  parameter int FCW    = 8
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      peakValid,
  input  logic [PIXELS*NP-1:0]      peakResult,
  output logic                      peakBusy,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [NP-1:0]             outData,
  output logic [$clog2(PIXELS)-1:0] outPixel,
  output logic                      outLast,
  output logic [FCW-1:0]            frameCnt,
  output logic                      overrun
);

  localparam int IW = $clog2(PIXELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PIXELS - 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [NP-1:0]        shadow [PIXELS];
  logic [NP-1:0]        cap    [PIXELS];
  logic [SLICE_MAX-1:0] ext;
  logic                 busy;
  logic                 is_last;
  logic                 capture;
  logic                 drop;

  assign ext     = SLICE_MAX'(peakResult);
  assign busy    = (state == SEND);
  assign is_last = (idx == LAST_IDX);
  // A frame arriving on the final handshake is accepted, keeping frames gap-free.
  assign capture = peakValid && (!busy || (outReady && is_last));
  assign drop    = peakValid && busy && !(outReady && is_last);

  for (genvar p = 0; p < PIXELS; p++) begin : g_pix
    logic [NP-1:0] raw;
    assign raw = NP'(pixel_slice(ext, p, NP));
`ifdef PEAK_IIR_EN
    peak_iir_cell #(.NP(NP)) u_iir (
      .clk      (clk),
      .res      (res),
      .new_val  (raw),
      .update   (capture),
      .filt_val (cap[p])
    );
`else
    assign cap[p] = raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      idx      <= '0;
      frameCnt <= '0;
      overrun  <= 1'b0;
      for (int unsigned p = 0; p < PIXELS; p++) shadow[p] <= '0;
    end else begin
      if (capture) begin
        for (int unsigned p = 0; p < PIXELS; p++) shadow[p] <= cap[p];
      end
      if (drop) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (capture) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (outReady) begin
            if (is_last) begin
              frameCnt <= frameCnt + FCW'(1);
              idx      <= '0;
              if (!capture) state <= IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
      endcase
    end
  end

  assign peakBusy = busy;
  assign outValid = busy;
  assign outData  = busy ? shadow[idx] : '0;
  assign outPixel = idx;
  assign outLast  = busy && is_last;

endmodule
